// File: rtl/proc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// proc_pkg : shared types and field helpers for the 9-bit processor
// Rev 1.0
// ---------------------------------------------------------------
package proc_pkg;

  localparam int DATA_W = 9;

  typedef enum logic [2:0] {
    OP_MV    = 3'd0,
    OP_MVI   = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_LD    = 3'd4,
    OP_ST    = 3'd5,
    OP_MVNZ  = 3'd6,
    OP_UNDEF = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_E1   = 3'd4,
    S_E2   = 3'd5,
    S_E3   = 3'd6
  } state_e;

  function automatic opcode_e ir_op(input logic [DATA_W-1:0] ir);
    return opcode_e'(ir[8:6]);
  endfunction

  function automatic logic [2:0] ir_rx(input logic [DATA_W-1:0] ir);
    return ir[5:3];
  endfunction

  function automatic logic [2:0] ir_ry(input logic [DATA_W-1:0] ir);
    return ir[2:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec3to8.sv
`default_nettype none
// ---------------------------------------------------------------
// dec3to8 : 3-bit index plus enable to one-hot 8-bit vector
// Rev 1.0
// ---------------------------------------------------------------
module dec3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign onehot[i] = en && (idx == 3'(i));
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ---------------------------------------------------------------
// control_unit : fetch/execute sequencer driving the 9-bit datapath
// Rev 1.0
// ---------------------------------------------------------------
module control_unit
  import proc_pkg::*;
#(
  parameter int DATA_W   = 9,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Run,
  input  logic [DATA_W-1:0] Din,
  input  logic [DATA_W-1:0] G,
  output logic              R0in,
  output logic              R1in,
  output logic              R2in,
  output logic              R3in,
  output logic              R4in,
  output logic              R5in,
  output logic              R6in,
  output logic              R7in,
  output logic              R0out,
  output logic              R1out,
  output logic              R2out,
  output logic              R3out,
  output logic              R4out,
  output logic              R5out,
  output logic              R6out,
  output logic              R7out,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic              Dinout,
  output logic              AddSub,
  output logic              ADDRin,
  output logic              Doutin,
  output logic              W_D,
  output logic              incr_pc,
  output logic [DATA_W-1:0] IR,
  output logic              Done
);

  localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYC - 1);

  state_e     state, state_nxt;
  logic [1:0] wait_cnt, wait_cnt_nxt;
  opcode_e    op;
  logic [2:0] rx, ry;
  logic       rx_in_en, rx_out_en, ry_out_en, r7_out_en;
  logic       waiting, wait_done, g_nz;
  logic [7:0] rin_vec, rout_rx, rout_ry, rout_vec;

  assign op        = ir_op(IR);
  assign rx        = ir_rx(IR);
  assign ry        = ir_ry(IR);
  assign wait_done = (wait_cnt == WAIT_LAST);
  assign g_nz      = |G;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      IR       <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == S_F2)
        IR <= Din;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    waiting      = 1'b0;
    rx_in_en     = 1'b0;
    rx_out_en    = 1'b0;
    ry_out_en    = 1'b0;
    r7_out_en    = 1'b0;
    Ain          = 1'b0;
    Gin          = 1'b0;
    Gout         = 1'b0;
    Dinout       = 1'b0;
    AddSub       = 1'b0;
    ADDRin       = 1'b0;
    Doutin       = 1'b0;
    W_D          = 1'b0;
    incr_pc      = 1'b0;
    Done         = 1'b0;

    case (state)
      S_IDLE: if (Run) state_nxt = S_F0;
      S_F0: begin
        r7_out_en = 1'b1;
        ADDRin    = 1'b1;
        state_nxt = S_F1;
      end
      // PC bumps once on entry; remaining cycles only cover memory latency
      S_F1: begin
        incr_pc   = (wait_cnt == 2'd0);
        waiting   = 1'b1;
        state_nxt = wait_done ? S_F2 : S_F1;
      end
      S_F2: state_nxt = S_E1;
      S_E1: begin
        state_nxt = S_E2;
        case (op)
          OP_MV: begin
            ry_out_en = 1'b1;
            rx_in_en  = 1'b1;
            Done      = 1'b1;
          end
          OP_MVI: begin
            r7_out_en = 1'b1;
            ADDRin    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rx_out_en = 1'b1;
            Ain       = 1'b1;
          end
          OP_LD, OP_ST: begin
            ry_out_en = 1'b1;
            ADDRin    = 1'b1;
          end
          OP_MVNZ: begin
            ry_out_en = g_nz;
            rx_in_en  = g_nz;
            Done      = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      S_E2: begin
        state_nxt = S_E3;
        case (op)
          OP_MVI: begin
            incr_pc = (wait_cnt == 2'd0);
            waiting = 1'b1;
            if (!wait_done) state_nxt = S_E2;
          end
          OP_LD: begin
            waiting = 1'b1;
            if (!wait_done) state_nxt = S_E2;
          end
          OP_ADD, OP_SUB: begin
            ry_out_en = 1'b1;
            Gin       = 1'b1;
            AddSub    = (op == OP_SUB);
          end
          OP_ST: begin
            rx_out_en = 1'b1;
            Doutin    = 1'b1;
            W_D       = 1'b1;
            Done      = 1'b1;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
      S_E3: begin
        case (op)
          OP_MVI, OP_LD: begin
            Dinout   = 1'b1;
            rx_in_en = 1'b1;
            Done     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Gout     = 1'b1;
            rx_in_en = 1'b1;
            Done     = 1'b1;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
      default: state_nxt = S_IDLE;
    endcase

    if (waiting && !wait_done)
      wait_cnt_nxt = wait_cnt + 2'd1;
    if (Done)
      state_nxt = Run ? S_F0 : S_IDLE;
  end

  dec3to8 u_rx_in  (.idx(rx), .en(rx_in_en),  .onehot(rin_vec));
  dec3to8 u_rx_out (.idx(rx), .en(rx_out_en), .onehot(rout_rx));
  dec3to8 u_ry_out (.idx(ry), .en(ry_out_en), .onehot(rout_ry));

  // At most one bus source is enabled in any step, so OR-merging is safe
  assign rout_vec = rout_rx | rout_ry | {r7_out_en, 7'b0};

  assign R0in  = rin_vec[0];
  assign R1in  = rin_vec[1];
  assign R2in  = rin_vec[2];
  assign R3in  = rin_vec[3];
  assign R4in  = rin_vec[4];
  assign R5in  = rin_vec[5];
  assign R6in  = rin_vec[6];
  assign R7in  = rin_vec[7];
  assign R0out = rout_vec[0];
  assign R1out = rout_vec[1];
  assign R2out = rout_vec[2];
  assign R3out = rout_vec[3];
  assign R4out = rout_vec[4];
  assign R5out = rout_vec[5];
  assign R6out = rout_vec[6];
  assign R7out = rout_vec[7];

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_control_unit : step-list reference model plus directed and random stimulus
// Rev 1.0
// ---------------------------------------------------------------
module tb_control_unit;

  localparam int WAIT_CYC = 1;

  logic       clk = 1'b0;
  logic       rst, Run;
  logic [8:0] Din, G, IR;
  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic Ain, Gin, Gout, Dinout, AddSub, ADDRin, Doutin, W_D, incr_pc, Done;

  always #5 clk = ~clk;

  control_unit #(.DATA_W(9), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst), .Run(Run), .Din(Din), .G(G),
    .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .R4in(R4in), .R5in(R5in), .R6in(R6in), .R7in(R7in),
    .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out),
    .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
    .Ain(Ain), .Gin(Gin), .Gout(Gout), .Dinout(Dinout), .AddSub(AddSub),
    .ADDRin(ADDRin), .Doutin(Doutin), .W_D(W_D), .incr_pc(incr_pc),
    .IR(IR), .Done(Done)
  );

  logic [25:0] dut_word;
  assign dut_word = {Done, incr_pc, W_D, Doutin, ADDRin, AddSub, Dinout, Gout, Gin, Ain,
                     R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out,
                     R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  localparam logic [25:0] W_AIN    = 26'd1 << 16;
  localparam logic [25:0] W_GIN    = 26'd1 << 17;
  localparam logic [25:0] W_GOUT   = 26'd1 << 18;
  localparam logic [25:0] W_DINOUT = 26'd1 << 19;
  localparam logic [25:0] W_ADDSUB = 26'd1 << 20;
  localparam logic [25:0] W_ADDR   = 26'd1 << 21;
  localparam logic [25:0] W_DOUTIN = 26'd1 << 22;
  localparam logic [25:0] W_WD     = 26'd1 << 23;
  localparam logic [25:0] W_INC    = 26'd1 << 24;
  localparam logic [25:0] W_DONE   = 26'd1 << 25;
  localparam logic [25:0] W_R7OUT  = 26'd1 << 15;
  localparam logic [25:0] W_F0     = W_R7OUT | W_ADDR;

  function automatic logic [25:0] w_rin(input logic [2:0] i);
    return 26'd1 << i;
  endfunction

  function automatic logic [25:0] w_rout(input logic [2:0] i);
    return 26'd1 << (8 + int'(i));
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: each instruction is a list of per-cycle control words.
  // Entry bits: [25:0] controls, [26] conditional on G!=0 (mvnz), [27] IR latch step.
  logic [27:0] mq[$];
  logic        mbusy;
  logic [8:0]  mir;

  function automatic void push_fetch();
    mq.push_back({2'b00, W_F0});
    mq.push_back({2'b00, W_INC});
    for (int k = 1; k < WAIT_CYC; k++) mq.push_back(28'd0);
    mq.push_back({2'b10, 26'd0});
  endfunction

  function automatic void push_exec(input logic [8:0] ins);
    logic [2:0] x, y;
    x = ins[5:3];
    y = ins[2:0];
    case (ins[8:6])
      3'd0: mq.push_back({2'b00, w_rout(y) | w_rin(x) | W_DONE});
      3'd1: begin
        mq.push_back({2'b00, W_F0});
        mq.push_back({2'b00, W_INC});
        for (int k = 1; k < WAIT_CYC; k++) mq.push_back(28'd0);
        mq.push_back({2'b00, W_DINOUT | w_rin(x) | W_DONE});
      end
      3'd2, 3'd3: begin
        mq.push_back({2'b00, w_rout(x) | W_AIN});
        mq.push_back({2'b00, w_rout(y) | W_GIN | ((ins[8:6] == 3'd3) ? W_ADDSUB : 26'd0)});
        mq.push_back({2'b00, W_GOUT | w_rin(x) | W_DONE});
      end
      3'd4: begin
        mq.push_back({2'b00, w_rout(y) | W_ADDR});
        for (int k = 0; k < WAIT_CYC; k++) mq.push_back(28'd0);
        mq.push_back({2'b00, W_DINOUT | w_rin(x) | W_DONE});
      end
      3'd5: begin
        mq.push_back({2'b00, w_rout(y) | W_ADDR});
        mq.push_back({2'b00, w_rout(x) | W_DOUTIN | W_WD | W_DONE});
      end
      3'd6: mq.push_back({2'b01, w_rout(y) | w_rin(x) | W_DONE});
      default: mq.push_back({2'b00, W_DONE});
    endcase
  endfunction

  function automatic logic [25:0] model_exp();
    if (!mbusy || mq.size() == 0) return 26'd0;
    if (mq[0][26] && G == 9'd0) return W_DONE;
    return mq[0][25:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mbusy <= 1'b0;
      mir   <= 9'd0;
    end else if (!mbusy) begin
      if (Run) begin
        push_fetch();
        mbusy <= 1'b1;
      end
    end else if (mq.size() == 0) begin
      mbusy <= 1'b0;
    end else if (mq[0][25]) begin
      mq.delete();
      if (Run) push_fetch();
      else mbusy <= 1'b0;
    end else if (mq[0][27]) begin
      void'(mq.pop_front());
      mir <= Din;
      push_exec(Din);
    end else begin
      void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("ctrl", dut_word, model_exp());
    chk("ir", {17'd0, IR}, {17'd0, mir});
  end

  int incs, dones;

  initial begin
    rst = 1'b1; Run = 1'b0; Din = 9'd0; G = 9'd0;
    @(negedge clk);
    chk("reset_ctrl", dut_word, 26'd0);
    chk("reset_ir", {17'd0, IR}, 26'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    // sub r1,r2
    #1 Din = 9'b011_001_010; Run = 1'b1; G = 9'h0a5;
    @(negedge clk); chk("sub_f0", dut_word, W_F0); #1 Run = 1'b0;
    @(negedge clk); chk("sub_f1", dut_word, W_INC);
    @(negedge clk); chk("sub_f2", dut_word, 26'd0);
    @(negedge clk); chk("sub_e1", dut_word, (26'd1 << 9) | W_AIN);
    chk("sub_ir", {17'd0, IR}, 26'b011_001_010);
    @(negedge clk); chk("sub_e2", dut_word, (26'd1 << 10) | W_GIN | W_ADDSUB);
    @(negedge clk); chk("sub_e3", dut_word, W_GOUT | 26'd2 | W_DONE);
    @(negedge clk); chk("sub_idle", dut_word, 26'd0);

    // add r3,r4 interrupted by reset in E2
    #1 Din = 9'b010_011_100; Run = 1'b1;
    @(negedge clk); #1 Run = 1'b0;
    repeat (4) @(negedge clk);
    chk("add_e2", dut_word, (26'd1 << 12) | W_GIN);
    #1 rst = 1'b1;
    #1 chk("rst_ctrl", dut_word, 26'd0);
    chk("rst_ir", {17'd0, IR}, 26'd0);
    @(negedge clk); #1 rst = 1'b0; Run = 1'b1;
    @(negedge clk); chk("rst_restart_f0", dut_word, W_F0); #1 Run = 1'b0;
    repeat (6) @(negedge clk);

    // mvi r3 with data 0x05
    incs = 0;
    #1 Din = 9'b001_011_000; Run = 1'b1;
    @(negedge clk); incs += int'(incr_pc); #1 Run = 1'b0;
    @(negedge clk); incs += int'(incr_pc);
    @(negedge clk); incs += int'(incr_pc);
    @(negedge clk); incs += int'(incr_pc); #1 Din = 9'h005;
    @(negedge clk); incs += int'(incr_pc);
    @(negedge clk); incs += int'(incr_pc);
    chk("mvi_e3", dut_word, (26'd1 << 3) | W_DINOUT | W_DONE);
    @(negedge clk); incs += int'(incr_pc);
    chk("mvi_incr_count", 26'(incs), 26'd2);

    // mvnz r0,r1 with G zero and nonzero
    for (int gi = 0; gi < 2; gi++) begin
      #1 Din = 9'b110_000_001; Run = 1'b1; G = (gi == 0) ? 9'h000 : 9'h001;
      @(negedge clk); #1 Run = 1'b0;
      repeat (3) @(negedge clk);
      chk(gi == 0 ? "mvnz_g0" : "mvnz_g1", dut_word,
          (gi == 0) ? W_DONE : ((26'd1 << 9) | 26'd1 | W_DONE));
      @(negedge clk);
    end

    // st r4,r5
    #1 Din = 9'b101_100_101; Run = 1'b1;
    @(negedge clk); #1 Run = 1'b0;
    repeat (3) @(negedge clk);
    chk("st_e1", dut_word, (26'd1 << 13) | W_ADDR);
    @(negedge clk); chk("st_e2", dut_word, (26'd1 << 12) | W_DOUTIN | W_WD | W_DONE);
    @(negedge clk); chk("st_wd_after", dut_word & W_WD, 26'd0);

    // three back-to-back mv r2,r6 with Run held
    dones = 0;
    #1 Din = 9'b000_010_110; Run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dones += int'(Done);
      if (i % 4 == 0) chk("mv_f0", dut_word, W_F0);
      if (i % 4 == 3) chk("mv_done", dut_word, (26'd1 << 14) | 26'd4 | W_DONE);
      if (i == 11) #1 Run = 1'b0;
    end
    chk("mv_done_count", 26'(dones), 26'd3);
    @(negedge clk); chk("mv_idle", dut_word, 26'd0);

    // randomized traffic, occasional asynchronous reset
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      Run = ($urandom_range(0, 3) != 0);
      Din = 9'($urandom);
      G   = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 150) == 0) rst = 1'b1;
    end
    #1 rst = 1'b0; Run = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
